lfsr_shuffler: RTL

- Parametrised, self-contained Fisher-Yates shuffler: owns its register file, FSM and datapath.
- Host loads entries 0..len_1, pulses start, and the block permutes them in place using an external LFSR `random` word.
- Done pulse on completion; host reads results through a combinational read port.
- Sits between the LFSR and downstream consumers of the permuted table.

---
 rtl/lfsr_shuffler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/lfsr_shuffler.sv
// In-place Fisher-Yates shuffler over a private register file, driven by an external random word.
// Optional LFSR_SHUFFLER_SKIP_SELF_EN: iterations that pick j==i skip the swap and cost one cycle.
module lfsr_shuffler #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int RAND_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len_1,
    input  logic [RAND_W-1:0] random,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int MOD_W = (RAND_W > ADDR_W + 1) ? RAND_W : ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, PICK, SWAP1, SWAP2, FINISH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] i, j, len_q;
    logic [DATA_W-1:0] temp;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   span;
    logic [MOD_W-1:0]  rem_w;
    logic [ADDR_W-1:0] j_pick;
    logic              last_iter;

    // span = len_q+1-i is at least 2 in PICK, so j_pick lands in [i, len_q]
    always_comb begin
        span      = ({1'b0, len_q} + (ADDR_W+1)'(1)) - {1'b0, i};
        rem_w     = MOD_W'(random) % MOD_W'(span);
        j_pick    = ADDR_W'((ADDR_W+1)'(rem_w) + {1'b0, i});
        last_iter = (i == len_q - ADDR_W'(1));
    end

    assign rd_data = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            temp  <= '0;
            len_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        i     <= '0;
                        len_q <= len_1;
                        busy  <= 1'b1;
                        if (len_1 == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= PICK;
                        end
                    end
                end
                PICK: begin
                    j <= j_pick;
`ifdef LFSR_SHUFFLER_SKIP_SELF_EN
                    if (j_pick == i) begin
                        if (last_iter) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            i     <= i + ADDR_W'(1);
                            state <= PICK;
                        end
                    end else begin
                        state <= SWAP1;
                    end
`else
                    state <= SWAP1;
`endif
                end
                SWAP1: begin
                    temp  <= mem[i];
                    state <= SWAP2;
                end
                SWAP2: begin
                    if (last_iter) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        i     <= i + ADDR_W'(1);
                        state <= PICK;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Host writes only land in IDLE; reset blocks every write so a reset cycle never half-swaps further
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == IDLE && wr_en)
                mem[wr_addr] <= wr_data;
            else if (state == SWAP1)
                mem[i] <= mem[j];
            else if (state == SWAP2)
                mem[j] <= temp;
        end
    end

endmodule
